manchester_tx_framer: RTL and testbench

MANCHESTER_TX_FRAMER -- requirements
Module: manchester_tx_framer

---
 rtl/manchester_tx_framer.sv | 151 +++++++++++++++
 tb/tb_manchester_tx_framer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_tx_framer.sv
// Manchester (IEEE 802.3) byte framer: preamble, MSB-first data, optional parity (MANCHESTER_PARITY_EN).
// Latency 1 cycle from accept to line; data_ready only in IDLE or the last cycle of a byte's final symbol.
module manchester_tx_framer #(
  parameter int HALF_BIT_CYCLES = 4,
  parameter int PREAMBLE_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       manchester_out,
  output logic       tx_active,
  output logic       frame_done
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_CYCLES - 1);
  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
`ifdef MANCHESTER_PARITY_EN
    DATA,
    PARITY
`else
    DATA
`endif
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] half_cnt;
  logic [7:0] bit_cnt;
  logic       second_half;
`ifdef MANCHESTER_PARITY_EN
  logic       parity_bit;
`endif

  logic bit_end;
  logic byte_end;
  logic cur_bit;

  always_comb begin
    bit_end  = second_half && (half_cnt == HALF_LAST);
    cur_bit  = shreg[7];
    byte_end = 1'b0;
    case (state)
      PREAMBLE: cur_bit = ~bit_cnt[0];
      DATA: begin
`ifndef MANCHESTER_PARITY_EN
        byte_end = (bit_cnt == 8'd7);
`endif
      end
`ifdef MANCHESTER_PARITY_EN
      PARITY: begin
        cur_bit  = parity_bit;
        byte_end = 1'b1;
      end
`endif
      default: ;
    endcase
    data_ready = !rst && ((state == IDLE) || (byte_end && bit_end));
  end

  // manchester_out always holds the half-bit currently on the line; a new
  // bit's first half is the inverse of that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= 8'd0;
      half_cnt       <= 8'd0;
      bit_cnt        <= 8'd0;
      second_half    <= 1'b0;
      manchester_out <= 1'b0;
      tx_active      <= 1'b0;
      frame_done     <= 1'b0;
`ifdef MANCHESTER_PARITY_EN
      parity_bit     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid) begin
            state          <= PREAMBLE;
            shreg          <= data_in;
`ifdef MANCHESTER_PARITY_EN
            parity_bit     <= ^data_in;
`endif
            bit_cnt        <= 8'd0;
            half_cnt       <= 8'd0;
            second_half    <= 1'b0;
            manchester_out <= 1'b0;
            tx_active      <= 1'b1;
          end
        end
        default: begin
          if (!bit_end) begin
            if (half_cnt == HALF_LAST) begin
              half_cnt       <= 8'd0;
              second_half    <= 1'b1;
              manchester_out <= cur_bit;
            end else begin
              half_cnt <= half_cnt + 8'd1;
            end
          end else begin
            half_cnt    <= 8'd0;
            second_half <= 1'b0;
            if (byte_end) begin
              bit_cnt <= 8'd0;
              if (data_valid) begin
                state          <= DATA;
                shreg          <= data_in;
`ifdef MANCHESTER_PARITY_EN
                parity_bit     <= ^data_in;
`endif
                manchester_out <= ~data_in[7];
              end else begin
                state          <= IDLE;
                manchester_out <= 1'b0;
                tx_active      <= 1'b0;
                frame_done     <= 1'b1;
              end
            end else if (state == PREAMBLE) begin
              if (bit_cnt == PRE_LAST) begin
                state          <= DATA;
                bit_cnt        <= 8'd0;
                manchester_out <= ~shreg[7];
              end else begin
                bit_cnt        <= bit_cnt + 8'd1;
                manchester_out <= ~bit_cnt[0];
              end
`ifdef MANCHESTER_PARITY_EN
            end else if (bit_cnt == 8'd7) begin
              state          <= PARITY;
              bit_cnt        <= 8'd0;
              manchester_out <= ~parity_bit;
`endif
            end else begin
              shreg          <= {shreg[6:0], 1'b0};
              bit_cnt        <= bit_cnt + 8'd1;
              manchester_out <= ~shreg[6];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx_framer.sv
// Bench for manchester_tx_framer: directed and random frames against a bit-list reference model.
module tb_manchester_tx_framer;

  localparam int H0 = 2;
  localparam int P0 = 4;
`ifdef MANCHESTER_PARITY_EN
  localparam int B  = 9;
  localparam int L1 = 20;
`else
  localparam int B  = 8;
  localparam int L1 = 18;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       manchester_out;
  logic       tx_active;
  logic       frame_done;

  logic [7:0] data_in1;
  logic       data_valid1;
  logic       data_ready1;
  logic       out1;
  logic       active1;
  logic       done1;

  manchester_tx_framer #(.HALF_BIT_CYCLES(H0), .PREAMBLE_BITS(P0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .manchester_out(manchester_out),
    .tx_active(tx_active), .frame_done(frame_done)
  );

  manchester_tx_framer #(.HALF_BIT_CYCLES(1), .PREAMBLE_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .data_valid(data_valid1),
    .data_ready(data_ready1), .manchester_out(out1),
    .tx_active(active1), .frame_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];
  logic       exp_q[$];
  logic       obs_q[$];
  int         act_cnt;
  int         done_cnt;
  int         first_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of bits (preamble, bytes MSB first, optional parity), then each bit as 2*h line cycles.
  task automatic build_exp(input int h, input int p);
    logic bits[$];
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < p; i++) bits.push_back(1'(i % 2 == 0));
    foreach (frame_q[k]) begin
      b = frame_q[k];
      for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
`ifdef MANCHESTER_PARITY_EN
      bits.push_back(^b);
`endif
    end
    foreach (bits[i]) begin
      repeat (h) exp_q.push_back(~bits[i]);
      repeat (h) exp_q.push_back(bits[i]);
    end
  endtask

  // Starts at a negedge with the DUT idle; offers frame_q back-to-back, junk on inputs when not ready.
  task automatic run_frame(input bit junk);
    int n, pre, sym, len, k;
    logic rdy;
    n   = frame_q.size();
    pre = P0 * 2 * H0;
    sym = B * 2 * H0;
    build_exp(H0, P0);
    len = exp_q.size();
    obs_q.delete();
    act_cnt = 0;
    done_cnt = 0;
    first_rdy = 0;
    chk("idle_ready", {31'd0, data_ready}, 1);
    chk("idle_out", {31'd0, manchester_out}, 0);
    data_in = frame_q[0];
    data_valid = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      obs_q.push_back(manchester_out);
      if (tx_active) act_cnt++;
      if (frame_done) done_cnt++;
      if (data_ready && first_rdy == 0) first_rdy = c;
      rdy = (c > pre) && ((c - pre) % sym == 0);
      chk("out", {31'd0, manchester_out}, {31'd0, exp_q[c-1]});
      chk("active", {31'd0, tx_active}, 1);
      chk("ready", {31'd0, data_ready}, {31'd0, rdy});
      if (rdy) begin
        k = (c - pre) / sym;
        data_valid = (k < n);
        data_in = (k < n) ? frame_q[k] : 8'($urandom);
      end else if (junk) begin
        data_valid = 1'($urandom);
        data_in = 8'($urandom);
      end else begin
        data_valid = 1'b0;
      end
    end
    data_valid = 1'b0;
    @(negedge clk);
    if (frame_done) done_cnt++;
    if (tx_active) act_cnt++;
    chk("done_pulse", {31'd0, frame_done}, 1);
    chk("end_active", {31'd0, tx_active}, 0);
    chk("end_out", {31'd0, manchester_out}, 0);
    chk("end_ready", {31'd0, data_ready}, 1);
    @(negedge clk);
    if (frame_done) done_cnt++;
    chk("done_once", {31'd0, frame_done}, 0);
  endtask

  logic [7:0]  obs8;
  logic [11:0] dec;
  logic [19:0] pat1;

  initial begin
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    data_valid1 = 1'b0;
    data_in1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out", {31'd0, manchester_out}, 0);
    chk("rst_active", {31'd0, tx_active}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_ready", {31'd0, data_ready}, 0);
    chk("rst_out1", {31'd0, out1}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, data_ready}, 1);
    chk("post_rst_ready1", {31'd0, data_ready1}, 1);

    // single byte 0xA5
    frame_q = '{8'hA5};
    run_frame(1'b0);
    for (int i = 0; i < 8; i++) obs8[7-i] = obs_q[i];
    chk("a5_first8", {24'd0, obs8}, 32'h3C);
    for (int i = 0; i < 12; i++) dec[11-i] = obs_q[i*2*H0 + H0];
    chk("a5_decode", {20'd0, dec}, 32'hAA5);
    chk("a5_active_len", act_cnt, (P0 + B) * 2 * H0);
    chk("a5_done_cnt", done_cnt, 1);

    // back-to-back 0x00, 0xFF with junk on inputs while not ready
    frame_q = '{8'h00, 8'hFF};
    run_frame(1'b1);
    chk("b2b_accept_cyc", first_rdy, (P0 + B) * 2 * H0);
    chk("b2b_active_len", act_cnt, (P0 + 2 * B) * 2 * H0);
    chk("b2b_done_cnt", done_cnt, 1);

    // reset mid-frame during data bit 3 of 0x3C
    data_in = 8'h3C;
    data_valid = 1'b1;
    for (int c = 1; c <= P0 * 2 * H0 + 3 * 2 * H0 + 2; c++) begin
      @(negedge clk);
      data_valid = 1'($urandom);
      data_in = 8'($urandom);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, data_ready}, 0);
    @(negedge clk);
    chk("mid_rst_out", {31'd0, manchester_out}, 0);
    chk("mid_rst_active", {31'd0, tx_active}, 0);
    chk("mid_rst_done", {31'd0, frame_done}, 0);
    rst = 1'b0;
    data_valid = 1'b0;
    #1;
    chk("mid_rst_ready_after", {31'd0, data_ready}, 1);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done || tx_active || manchester_out) done_cnt++;
    end
    chk("mid_rst_quiet", done_cnt, 0);

    // random frames of 1..3 bytes with random idle gaps
    for (int f = 0; f < 5; f++) begin
      frame_q.delete();
      repeat ($urandom_range(1, 3)) frame_q.push_back(8'($urandom));
      run_frame(1'b1);
      chk("rnd_active_len", act_cnt, (P0 + frame_q.size() * B) * 2 * H0);
      chk("rnd_done_cnt", done_cnt, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // one-cycle half-bits, one preamble bit, byte 0x80
`ifdef MANCHESTER_PARITY_EN
    pat1 = 20'b01011010101010101001;
`else
    pat1 = 20'b00010110101010101010;
`endif
    data_in1 = 8'h80;
    data_valid1 = 1'b1;
    for (int c = 0; c < L1; c++) begin
      @(negedge clk);
      data_valid1 = 1'b0;
      data_in1 = 8'($urandom);
      chk("d1_out", {31'd0, out1}, {31'd0, pat1[L1-1-c]});
      chk("d1_active", {31'd0, active1}, 1);
    end
    @(negedge clk);
    chk("d1_done", {31'd0, done1}, 1);
    chk("d1_end_active", {31'd0, active1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
